// File: rtl/iob_uart_rxbuf.sv
// UART receive buffer: drains the core's rx handshake into a FIFO and
// presents bytes on a valid/ready stream with level, irq and overrun status.
module iob_uart_rxbuf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  core_rx_ready_i,
    input  logic [DATA_W-1:0]     core_rx_data_i,
    output logic                  core_read_en_o,
    output logic                  m_valid_o,
    output logic [DATA_W-1:0]     m_data_o,
    input  logic                  m_ready_i,
    output logic [DEPTH_LOG2:0]   level_o,
    input  logic [DEPTH_LOG2:0]   thresh_i,
    output logic                  irq_o,
    output logic                  overrun_o,
    output logic [7:0]            drop_cnt_o,
    input  logic                  overrun_clr_i,
    input  logic                  flush_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        HOLD
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                capture;
    logic                pop;
    logic                full;
    logic                push;
    logic                drop;

    // Fullness is judged after a same-cycle pop, so a full FIFO being
    // drained can still accept the incoming byte.
    always_comb begin
        pop     = m_valid_o && m_ready_i && !flush_i;
        full    = (level_o == FULL_LVL);
        capture = (state == IDLE) && en_i && core_rx_ready_i && !flush_i;
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    assign m_valid_o = (level_o != '0);
    assign m_data_o  = mem[rd_ptr];
    assign irq_o     = (thresh_i != '0) && (level_o >= thresh_i);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            core_read_en_o <= 1'b0;
        end else begin
            core_read_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        state          <= ACK;
                        core_read_en_o <= 1'b1;
                    end
                end
                ACK:  state <= HOLD;
                HOLD: begin
                    if (!core_rx_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      level_o <= level_o + LVL_ONE;
            else if (pop && !push) level_o <= level_o - LVL_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && push) mem[wr_ptr] <= core_rx_data_i;
    end

    // A clear in the same cycle as a drop wins.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            overrun_o  <= 1'b0;
            drop_cnt_o <= 8'd0;
        end else if (overrun_clr_i) begin
            overrun_o  <= 1'b0;
            drop_cnt_o <= 8'd0;
        end else if (drop) begin
            overrun_o <= 1'b1;
            if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end

endmodule

// File: doc/iob_uart_rxbuf.md
# iob_uart_rxbuf

Receive-side buffer that sits directly downstream of the UART core. It drains each received byte from the core's rx_ready/rx_data/read-strobe handshake into a FIFO and presents the bytes on a valid/ready stream. It also reports the fill level, a threshold interrupt, and overrun status. This lets software or a DMA engine fetch bytes in bursts without losing characters between polls.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 bytes (range 1..8).
- DATA_W, 8: byte width, fixed at 8.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_n_i  in  1  reset; one clock, reset synchronous and active-low.
- en_i  in  1  enables draining of the core.
- core_rx_ready_i  in  1  core holds a received byte.
- core_rx_data_i  in  8  byte held by the core.
- core_read_en_o  out  1  one-cycle read strobe to the core; the core clears rx_ready in response.
- m_valid_o  out  1  FIFO non-empty.
- m_data_o  out  8  FIFO head byte.
- m_ready_i  in  1  consumer accepts the head byte.
- level_o  out  DEPTH_LOG2+1  current occupancy.
- thresh_i  in  DEPTH_LOG2+1  interrupt threshold; 0 disables the interrupt.
- irq_o  out  1  asserted when level_o >= thresh_i and thresh_i != 0.
- overrun_o  out  1  sticky flag: a byte was dropped because the FIFO was full.
- drop_cnt_o  out  8  number of dropped bytes, saturating at 255.
- overrun_clr_i  in  1  clears overrun_o and drop_cnt_o.
- flush_i  in  1  empties the FIFO.

## Operation
- The capture FSM has three states: IDLE, ACK, HOLD.
- IDLE: if en_i and core_rx_ready_i and !flush_i, capture core_rx_data_i and go to ACK.
  - The capture is a push if the FIFO is not full.
  - Otherwise the byte is a drop: overrun_o is set and drop_cnt_o increments unless it is already 255.
- ACK: core_read_en_o=1 for exactly this cycle; go to HOLD.
- HOLD: stay until core_rx_ready_i is sampled low, then go to IDLE. This prevents double-capture of one byte. If rx_ready stays stuck high, the FSM stays in HOLD indefinitely.
- If en_i drops during ACK or HOLD, the sequence still completes.
- FIFO:
  - Register array with read/write pointers of DEPTH_LOG2 bits that wrap modulo depth.
  - level_o is a separate counter.
  - m_data_o = mem[rd_ptr] (show-ahead).
- Pop occurs when m_valid_o and m_ready_i are both high.
- Push and pop in the same cycle:
  - Both are performed and level is unchanged.
  - A push while full is still accepted if a pop occurs in the same cycle (full is evaluated after the pop); no overrun in that case.
- Pop when empty is ignored.
- flush_i has priority over push and pop:
  - Pointers and level go to 0 at the next edge.
  - The FSM does not leave IDLE during a flush cycle.
  - overrun_o and drop_cnt_o are unaffected.
- overrun_clr_i in the same cycle as a drop: the clear wins, giving overrun_o=0 and drop_cnt_o=0.
- irq_o is combinational from the level register and thresh_i.

## Timing
- Reset values:
  - FSM in IDLE, pointers 0.
  - core_read_en_o=0, m_valid_o=0, m_data_o=mem[0] (content don't-care).
  - level_o=0, irq_o=0 if thresh_i is 0 or greater than 0 with level 0, overrun_o=0, drop_cnt_o=0.
- Reset takes effect at the clock edge where rst_n_i is sampled low; it overrides any in-progress ACK or HOLD.
- A byte becomes visible one cycle after it is available:
  - core_rx_ready_i is high at edge t with the FSM in IDLE.
  - At t+1: m_valid_o=1 with the byte, level incremented, core_read_en_o=1.
  - The FSM is in HOLD from t+2.
- Minimum spacing between captures is 3 cycles (IDLE, ACK, HOLD with rx_ready already low).
- A pop at edge t updates m_data_o and level_o at t+1.
- Throughput: one pop per cycle on the stream side.

## Test plan
- Single byte: core presents 0xA5 with en_i=1 → one core_read_en_o pulse 1 cycle later, m_valid_o=1 with m_data_o=0xA5, level_o=1. After m_ready_i for one cycle: level_o=0, m_valid_o=0.
- Fill and overrun, DEPTH_LOG2=2, m_ready_i=0:
  - Push 0x01..0x06 → level_o=4, overrun_o=1, drop_cnt_o=2, exactly 6 read strobes.
  - Drain → 0x01,0x02,0x03,0x04 in order.
- Pointer wrap and simultaneous push/pop: with level 4 (full), assert m_ready_i in the same cycle as a capture of 0x77 → no overrun, level stays 4. 0x77 emerges as the 4th byte after the pointers wrap.
- Threshold interrupt: thresh_i=3 → irq_o rises with the 3rd push and falls when one byte is popped. With thresh_i=0, irq_o stays 0 with a full FIFO.
- HOLD robustness: keep core_rx_ready_i high for 10 cycles after the strobe → exactly one push, one strobe. A second byte is captured only after rx_ready goes low and then high again.
- Flush and reset:
  - flush_i with level 3 and a byte pending on the core → level 0 next cycle, no strobe in the flush cycle, byte captured the cycle after, overrun_o unchanged.
  - rst_n_i=0 during HOLD → all outputs at reset values next cycle.
